sar_search_controller: RTL and testbench
========================================

# sar_search_controller

Successive-approximation search engine that sits on the operand side of the lab's 4-bit magnitude comparator. It drives the comparator's B operand with trial values and consumes its L/G/E outputs, where A is an unknown value held elsewhere. It binary-searches A and reports the value found and the probe count. It is the controller half of the comparator-based "guess the number" and SAR-converter labs.

## Interface
- WIDTH, 4: operand width; search range 0 .. 2^WIDTH-1.
- SW, $clog2(WIDTH+2): width of the steps counter.

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a search; sampled in IDLE and DONE only.
- cmp_l  in  1  comparator L: A < trial.
- cmp_g  in  1  comparator G: A > trial.
- cmp_e  in  1  comparator E: A == trial.
- trial  out  WIDTH  registered operand driven to comparator input B.
- busy  out  1  high while a search is in progress.
- done  out  1  one-cycle pulse when a search terminates.
- found  out  1  last search matched; held until next start.
- err  out  1  last search aborted on an illegal comparator code; held until next start.
- result  out  WIDTH  matched value, valid when found=1; held until next start.
- steps  out  SW  number of probes sampled in the last or current search.

## Operation
- States: IDLE, SEARCH, (SETTLE, see Configuration), DONE.
- Internal bounds lo and hi are WIDTH+1 bits wide, so that lo=trial+1 cannot overflow and hi=trial-1 cannot underflow. The midpoint is computed as (lo+hi)>>1 with a WIDTH+2-bit sum; trial takes its low WIDTH bits.
- IDLE/DONE + start=1:
  - lo←0, hi←2^WIDTH-1, trial←(2^WIDTH-1)>>1 (7 for WIDTH=4).
  - steps←0; found, err and result are cleared.
  - Go to SEARCH.
- SEARCH, each cycle, sample the cmp inputs and increment steps:
  - cmp_e only: result←trial, found←1, go to DONE.
  - cmp_g only: lo←trial+1.
  - cmp_l only: hi←trial-1.
  - Any other code (none asserted, or more than one asserted): err←1, go to DONE.
  - After a G or L update, if the new lo > new hi: go to DONE with found=0 and err=0 (inconsistent A).
  - Otherwise trial←midpoint of the new lo/hi, registered on the same edge.
- DONE: done=1 for exactly this cycle.
  - start=1 in this cycle starts a new search directly.
  - Otherwise go to IDLE.
- start is ignored while busy=1. The cmp inputs are ignored outside SEARCH.
- Reset values: state=IDLE, trial=0, busy=0, done=0, found=0, err=0, result=0, steps=0, lo=0, hi=0.
- rst_n assertion mid-search aborts immediately to these values. No done pulse is produced.

## Timing
- trial changes only on clock edges. The comparator is combinational, so cmp inputs are sampled in the same cycle that trial is presented.
- busy rises the cycle after start is sampled and falls in the DONE cycle.
- Latency from start to done, with the build macro not defined, is probes+1 cycles, where probes ≤ WIDTH+1.
- result, found, err and steps are valid from the DONE cycle onward.

## Configuration
- SAR_SETTLE_EN defined:
  - A SETTLE state is inserted before every SEARCH sample, both after start and after each trial update.
  - This allows one extra cycle for a registered comparator or for long routing.
  - Each probe costs 2 cycles; start-to-done latency is 2·probes+1.
  - busy is high in SETTLE. The cmp inputs are ignored in SETTLE.
- SAR_SETTLE_EN not defined: SETTLE does not exist; one probe per cycle.

## Test plan
- A=0 (comparator model wired to trial) -> trial sequence 7,3,1,0; found=1, result=0, steps=4, done pulses 5 cycles after start.
- A=15 -> trial sequence 7,11,13,14,15; found=1, result=15, steps=5.
- A=7 -> single probe; found=1, result=7, steps=1, done 2 cycles after start. A start in the DONE cycle immediately begins a new search at trial=7.
- Force cmp_l=cmp_g=1 on the second probe -> err=1, found=0, steps=2, done pulse. Also force cmp_g=1 constantly -> terminates with lo>hi after 5 probes; found=0, err=0.
- Pulse start again during SEARCH -> ignored; trace is identical to the undisturbed run.
- Deassert rst_n mid-search (on the third probe of an A=0 run) -> all outputs 0 asynchronously, no done pulse.
- Repeat with SAR_SETTLE_EN -> A=0 needs 4 probes and gives done 9 cycles after start.

Source files
------------

// File: rtl/sar_search_controller.sv
// sar_search_controller: binary search of a comparator's unknown operand A by driving trial values on B.
// Define SAR_SETTLE_EN to insert a SETTLE cycle before every comparator sample.
module sar_search_controller #(
    parameter int WIDTH = 4,
    parameter int SW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_l,
    input  logic             cmp_g,
    input  logic             cmp_e,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [SW-1:0]    steps
);
    typedef enum logic [1:0] {IDLE, SEARCH, SETTLE, DONE} state_t;
`ifdef SAR_SETTLE_EN
    localparam state_t PROBE = SETTLE;
`else
    localparam state_t PROBE = SEARCH;
`endif
    localparam logic [WIDTH:0] TOP = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] ONE = 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d, result_q, result_d;
    logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d, lo_n, hi_n;
    logic [WIDTH+1:0] sum;
    logic [SW-1:0]    steps_q, steps_d;
    logic             found_q, found_d, err_q, err_d;
    logic [2:0]       code;

    assign code = {cmp_l, cmp_g, cmp_e};

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        steps_d  = steps_q;
        found_d  = found_q;
        err_d    = err_q;
        result_d = result_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        sum      = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lo_d     = '0;
                    hi_d     = TOP;
                    trial_d  = WIDTH'(TOP >> 1);
                    steps_d  = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = PROBE;
                end else begin
                    state_d  = IDLE;
                end
            end
            SETTLE: state_d = SEARCH;
            SEARCH: begin
                steps_d = steps_q + SW'(1);
                if (code == 3'b001) begin
                    result_d = trial_q;
                    found_d  = 1'b1;
                    state_d  = DONE;
                end else if (code == 3'b010 || code == 3'b100) begin
                    lo_n = cmp_g ? {1'b0, trial_q} + ONE : lo_q;
                    hi_n = cmp_l ? {1'b0, trial_q} - ONE : hi_q;
                    lo_d = lo_n;
                    hi_d = hi_n;
                    sum  = {1'b0, lo_n} + {1'b0, hi_n};
                    // hi may be -1 after L at trial 0; its top bit acts as a sign
                    if ($signed({1'b0, lo_n}) > $signed({hi_n[WIDTH], hi_n})) begin
                        state_d = DONE;
                    end else begin
                        trial_d = WIDTH'(sum >> 1);
                        state_d = PROBE;
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            steps_q  <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            steps_q  <= steps_d;
            found_q  <= found_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign trial  = trial_q;
    assign busy   = (state_q == SEARCH) || (state_q == SETTLE);
    assign done   = (state_q == DONE);
    assign found  = found_q;
    assign err    = err_q;
    assign result = result_q;
    assign steps  = steps_q;
endmodule

// File: tb/tb_sar_search_controller.sv
// tb_sar_search_controller: directed checks of the SAR search controller against a comparator model.
// Expected latencies scale with SAR_SETTLE_EN (two cycles per probe when defined).
module tb_sar_search_controller;
`ifdef SAR_SETTLE_EN
    localparam int SPP = 2;
`else
    localparam int SPP = 1;
`endif
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       cmp_l, cmp_g, cmp_e, busy, done, found, err;
    logic [3:0] trial, result;
    logic [2:0] steps;
    logic [3:0] a_val = 4'd0;
    logic [3:0] trace [64];
    int         mode = 0, ntr = 0, lat = 0, pulse_at = -1;
    int         checks = 0, errors = 0;

    sar_search_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cmp_l(cmp_l), .cmp_g(cmp_g), .cmp_e(cmp_e),
        .trial(trial), .busy(busy), .done(done), .found(found),
        .err(err), .result(result), .steps(steps)
    );

    always #5 clk = ~clk;

    // Comparator model: mode 1 forces G always, mode 2 forces L+G on the second probe.
    always_comb begin
        cmp_l = a_val < trial;
        cmp_g = a_val > trial;
        cmp_e = a_val == trial;
        if (mode == 1) {cmp_l, cmp_g, cmp_e} = 3'b010;
        if (mode == 2 && steps == 3'd1) {cmp_l, cmp_g, cmp_e} = 3'b110;
    end

    task automatic run(input logic [3:0] a, input int m);
        a_val = a;
        mode  = m;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        ntr = 0;
        while (!done && lat < 60) begin
            if (busy && ntr < 64) begin
                trace[ntr] = trial;
                ntr++;
            end
            start = (lat == pulse_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({trial, busy, done, found, err, result, steps} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {trial, busy, done, found, err, result, steps});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_a0();
        logic [3:0] exp [4] = '{4'd7, 4'd3, 4'd1, 4'd0};
        run(4'd0, 0);
        checks++;
        if (lat !== 4 * SPP + 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL a0_latency: got %0d done=%b expected %0d", lat, done, 4 * SPP + 1);
        end
        checks++;
        if ({found, err, result, steps} !== {1'b1, 1'b0, 4'd0, 3'd4}) begin
            errors++;
            $display("FAIL a0_result: got found=%b err=%b result=%0d steps=%0d expected 1 0 0 4", found, err, result, steps);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (trace[i * SPP] !== exp[i]) begin
                errors++;
                $display("FAIL a0_trial%0d: got %0d expected %0d", i, trace[i * SPP], exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({done, busy, found, result} !== {1'b0, 1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL a0_after_done: got done=%b busy=%b found=%b result=%0d expected 0 0 1 0", done, busy, found, result);
        end
    endtask

    task automatic test_a15();
        logic [3:0] exp [5] = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        run(4'd15, 0);
        checks++;
        if (lat !== 5 * SPP + 1 || {found, err, result, steps} !== {1'b1, 1'b0, 4'd15, 3'd5}) begin
            errors++;
            $display("FAIL a15_result: got lat=%0d found=%b err=%b result=%0d steps=%0d expected %0d 1 0 15 5", lat, found, err, result, steps, 5 * SPP + 1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (trace[i * SPP] !== exp[i]) begin
                errors++;
                $display("FAIL a15_trial%0d: got %0d expected %0d", i, trace[i * SPP], exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        run(4'd7, 0);
        checks++;
        if (lat !== SPP + 1 || {found, result, steps} !== {1'b1, 4'd7, 3'd1}) begin
            errors++;
            $display("FAIL a7_result: got lat=%0d found=%b result=%0d steps=%0d expected %0d 1 7 1", lat, found, result, steps, SPP + 1);
        end
        a_val = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, done, trial, steps, found} !== {1'b1, 1'b0, 4'd7, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b done=%b trial=%0d steps=%0d found=%b expected 1 0 7 0 0", busy, done, trial, steps, found);
        end
        c = 1;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c !== 3 * SPP + 1 || {found, result, steps} !== {1'b1, 4'd5, 3'd3}) begin
            errors++;
            $display("FAIL b2b_a5: got lat=%0d found=%b result=%0d steps=%0d expected %0d 1 5 3", c, found, result, steps, 3 * SPP + 1);
        end
    endtask

    task automatic test_err();
        run(4'd0, 2);
        checks++;
        if (lat !== 2 * SPP + 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL err_latency: got %0d done=%b expected %0d", lat, done, 2 * SPP + 1);
        end
        checks++;
        if ({found, err, steps} !== {1'b0, 1'b1, 3'd2}) begin
            errors++;
            $display("FAIL err_flags: got found=%b err=%b steps=%0d expected 0 1 2", found, err, steps);
        end
        mode = 0;
    endtask

    task automatic test_gconst();
        logic [3:0] exp [5] = '{4'd7, 4'd11, 4'd13, 4'd14, 4'd15};
        run(4'd0, 1);
        checks++;
        if (lat !== 5 * SPP + 1 || {found, err, steps} !== {1'b0, 1'b0, 3'd5}) begin
            errors++;
            $display("FAIL gconst_result: got lat=%0d found=%b err=%b steps=%0d expected %0d 0 0 5", lat, found, err, steps, 5 * SPP + 1);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (trace[i * SPP] !== exp[i]) begin
                errors++;
                $display("FAIL gconst_trial%0d: got %0d expected %0d", i, trace[i * SPP], exp[i]);
            end
        end
        mode = 0;
    endtask

    task automatic test_start_ignored();
        logic [3:0] exp [4] = '{4'd7, 4'd3, 4'd1, 4'd0};
        pulse_at = 2;
        run(4'd0, 0);
        pulse_at = -1;
        checks++;
        if (lat !== 4 * SPP + 1 || ntr !== 4 * SPP || {found, result, steps} !== {1'b1, 4'd0, 3'd4}) begin
            errors++;
            $display("FAIL ignore_start: got lat=%0d busy_cycles=%0d found=%b result=%0d steps=%0d expected %0d %0d 1 0 4", lat, ntr, found, result, steps, 4 * SPP + 1, 4 * SPP);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (trace[i * SPP] !== exp[i]) begin
                errors++;
                $display("FAIL ignore_trial%0d: got %0d expected %0d", i, trace[i * SPP], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        logic seen_done;
        a_val = 4'd0;
        mode  = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!(busy && steps == 3'd2) && c < 60) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (trial !== 4'd1) begin
            errors++;
            $display("FAIL mid_third_probe: got trial=%0d expected 1", trial);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({trial, busy, done, found, err, result, steps} !== 15'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got %h expected 0", {trial, busy, done, found, err, result, steps});
        end
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen_done |= done;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_done |= done | busy;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done: got done_or_busy=%b expected 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_a0();
        test_a15();
        test_back_to_back();
        test_err();
        test_gconst();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
